// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified, variable-latency memory port between the instruction
// fetch requester (IF) and the data load/store requester (DM). Ties are
// resolved round-robin. The winning request is registered at grant, so the
// memory sees stable fields for the whole access. An optional ack timeout
// ends a stuck access with an error pulse.
//
// Access flow: IDLE (arbitrate + capture) -> REQ (wait for mem_ack) ->
// RESP (one-cycle ready pulse to the owner) -> IDLE. The minimum is three
// cycles per access.
//
// Parameters
//   DATA_WIDTH      data bus width, multiple of 8
//   ADDR_WIDTH      byte address width
//   TIMEOUT_CYCLES  max cycles spent in REQ without mem_ack; 0 disables
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   if_req/if_addr            fetch request; held until if_ready
//   if_ready/if_rdata         fetch done pulse, fetched word (held until next)
//   dm_req/we/addr/wdata/be   data request; held until dm_ready
//   dm_ready/dm_rdata         data done pulse, load data (0 after a store)
//   mem_req/we/addr/wdata/be  registered memory request, mem_req held to ack
//   mem_ack/mem_rdata         memory completion, read data valid with ack
//   err                       pulses with the ready of a timed-out access
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ready,
    output logic [DATA_WIDTH-1:0]   if_rdata,

    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_be,
    output logic                    dm_ready,
    output logic [DATA_WIDTH-1:0]   dm_rdata,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    err
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    // The counter only ever reaches TIMEOUT_CYCLES-1, so clog2 bits suffice.
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                 state_q,      state_d;
    port_e                  last_grant_q, last_grant_d;
    port_e                  owner_q,      owner_d;
    logic [CNT_WIDTH-1:0]   tmo_cnt_q,    tmo_cnt_d;

    logic                   mem_req_q,    mem_req_d;
    logic                   mem_we_q,     mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q,  mem_wdata_d;
    logic [BE_WIDTH-1:0]    mem_be_q,     mem_be_d;

    logic                   if_ready_q,   if_ready_d;
    logic [DATA_WIDTH-1:0]  if_rdata_q,   if_rdata_d;
    logic                   dm_ready_q,   dm_ready_d;
    logic [DATA_WIDTH-1:0]  dm_rdata_q,   dm_rdata_d;
    logic                   err_q,        err_d;

    // -------------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on a tie the port that did
    // not win last time is granted.
    // -------------------------------------------------------------------------
    logic  grant_valid;
    port_e grant_port;

    always_comb begin
        grant_valid = if_req || dm_req;
        if (if_req && dm_req) begin
            grant_port = (last_grant_q == PORT_IF) ? PORT_DM : PORT_IF;
        end else if (dm_req) begin
            grant_port = PORT_DM;
        end else begin
            grant_port = PORT_IF;
        end
    end

    // -------------------------------------------------------------------------
    // Timeout: fires on the last allowed REQ cycle only when no ack arrives,
    // so an ack on that very cycle still completes normally.
    // -------------------------------------------------------------------------
    logic timeout_hit;

    always_comb begin
        timeout_hit = TIMEOUT_EN && (tmo_cnt_q == CNT_LAST) && !mem_ack;
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        tmo_cnt_d    = tmo_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        // Ready and err are single-cycle pulses, so they default low.
        if_ready_d   = 1'b0;
        dm_ready_d   = 1'b0;
        err_d        = 1'b0;
        resp_valid   = 1'b0;
        resp_data    = '0;

        unique case (state_q)
            ST_IDLE: begin
                tmo_cnt_d = '0;
                if (grant_valid) begin
                    owner_d      = grant_port;
                    last_grant_d = grant_port;
                    mem_req_d    = 1'b1;
                    state_d      = ST_REQ;
                    if (grant_port == PORT_DM) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_be_d    = dm_be;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                    end
                end
            end

            ST_REQ: begin
                if (mem_ack) begin
                    // Stores return no data; only loads and fetches see mem_rdata.
                    resp_valid = 1'b1;
                    resp_data  = mem_we_q ? '0 : mem_rdata;
                end else if (timeout_hit) begin
                    resp_valid = 1'b1;
                    resp_data  = '0;
                    err_d      = 1'b1;
                end else if (TIMEOUT_EN) begin
                    tmo_cnt_d = tmo_cnt_q + CNT_WIDTH'(1);
                end

                if (resp_valid) begin
                    mem_req_d = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = ST_RESP;
                    if (owner_q == PORT_DM) begin
                        dm_ready_d = 1'b1;
                        dm_rdata_d = resp_data;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = resp_data;
                    end
                end
            end

            ST_RESP: begin
                // The ready pulse is already on the outputs this cycle.
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                tmo_cnt_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            // NOTE: the request and read-data registers are cleared as well as
            // the control state, because every output must read 0 in reset.
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_IF;
            owner_q      <= PORT_IF;
            tmo_cnt_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_ready_q   <= 1'b0;
            if_rdata_q   <= '0;
            dm_ready_q   <= 1'b0;
            dm_rdata_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            tmo_cnt_q    <= tmo_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            if_ready_q   <= if_ready_d;
            if_rdata_q   <= if_rdata_d;
            dm_ready_q   <= dm_ready_d;
            dm_rdata_q   <= dm_rdata_d;
            err_q        <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all driven straight from flops.
    // -------------------------------------------------------------------------
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ready  = dm_ready_q;
    assign dm_rdata  = dm_rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with TIMEOUT_CYCLES=4. A table of single
// transactions with hand-computed latency, error and read data runs in a loop.
// Reset, contention, stray-ack and reset-mid-access sequences are hand-written
// around it. Inputs change and outputs are sampled 1 time unit after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BW  = DW / 8;
    localparam int TMO = 4;
    localparam logic [DW-1:0] MASK = 32'hA5A5_0000;
    localparam int NO_ACK = 99;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [BW-1:0] dm_be;
    logic          dm_ready;
    logic [DW-1:0] dm_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_be    (dm_be),
        .dm_ready (dm_ready),
        .dm_rdata (dm_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .err      (err)
    );

    int total = 0;
    int bad   = 0;

    // Last value each rdata output must be holding.
    logic [DW-1:0] exp_if_rdata;
    logic [DW-1:0] exp_dm_rdata;

    typedef struct {
        logic          is_dm;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        int            ack_dly;    // cycles after mem_req rises before ack
        logic [DW-1:0] rd;         // value on mem_rdata while serving
        logic          wiggle;     // change requester fields while owned
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;    // cycles from request-sample to ready
    } txn_t;

    txn_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_be     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    // Called #1 after an edge with the DUT in IDLE; that cycle is N.
    task automatic run_txn(input txn_t t, input int idx);
        logic          exp_we;
        logic [BW-1:0] exp_be;
        bit            got;
        bit            stable;
        int            lat;
        int            req_cycles;
        logic          r_if, r_dm, r_err, r_req;
        logic [DW-1:0] rd_if, rd_dm;

        exp_we = t.is_dm ? t.we : 1'b0;
        exp_be = t.is_dm ? t.be : {BW{1'b1}};
        if (t.is_dm) begin
            dm_req = 1'b1; dm_we = t.we; dm_addr = t.addr; dm_wdata = t.wdata; dm_be = t.be;
        end else begin
            if_req = 1'b1; if_addr = t.addr;
        end

        got = 1'b0; stable = 1'b1; lat = 0; req_cycles = 0;
        r_if = 1'b0; r_dm = 1'b0; r_err = 1'b0; r_req = 1'b0; rd_if = '0; rd_dm = '0;
        for (int c = 1; c <= 20 && !got; c++) begin
            tick();
            if (if_ready || dm_ready) begin
                got = 1'b1; lat = c;
                r_if = if_ready; r_dm = dm_ready; r_err = err; r_req = mem_req;
                rd_if = if_rdata; rd_dm = dm_rdata;
                mem_ack = 1'b0; if_req = 1'b0; dm_req = 1'b0;
            end else begin
                if (mem_req) begin
                    req_cycles++;
                    if (mem_we !== exp_we || mem_addr !== t.addr || mem_be !== exp_be ||
                        (t.is_dm && mem_wdata !== t.wdata))
                        stable = 1'b0;
                end
                if (t.wiggle) begin
                    if_addr = ~t.addr; dm_addr = ~t.addr; dm_wdata = ~t.wdata;
                    dm_be = ~t.be; dm_we = ~t.we;
                end
                mem_ack   = (c - 1 == t.ack_dly);
                mem_rdata = t.rd;
            end
        end

        check($sformatf("txn%0d_ready_seen", idx), got, 1);
        if (got) begin
            if (t.is_dm) exp_dm_rdata = t.exp_rdata;
            else         exp_if_rdata = t.exp_rdata;
            check($sformatf("txn%0d_latency", idx), lat, t.exp_lat);
            check($sformatf("txn%0d_ready_port", idx), {r_if, r_dm}, t.is_dm ? 2'b01 : 2'b10);
            check($sformatf("txn%0d_err", idx), r_err, t.exp_err);
            check($sformatf("txn%0d_mem_req_in_resp", idx), r_req, 0);
            check($sformatf("txn%0d_mem_req_cycles", idx), req_cycles, t.exp_lat - 1);
            check($sformatf("txn%0d_mem_fields", idx), stable, 1);
            check($sformatf("txn%0d_if_rdata", idx), rd_if, exp_if_rdata);
            check($sformatf("txn%0d_dm_rdata", idx), rd_dm, exp_dm_rdata);
            tick();
            check($sformatf("txn%0d_pulse_end", idx), {if_ready, dm_ready, err, mem_req}, 0);
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ng;
        int            seen;
        logic [1:0]    ports [4];
        logic [DW-1:0] rds   [4];
        txn_t          fresh;

        // idx: is_dm we addr wdata be ack_dly rd wiggle exp_rdata exp_err exp_lat
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'h0,    0,      32'h0050_0513, 1'b0, 32'h0050_0513, 1'b0, 2};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, 3,      32'h1234_5678, 1'b0, 32'h0,         1'b0, 5};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,         4'hF,    1,      32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0, 3};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'h0,    NO_ACK, 32'h1111_1111, 1'b0, 32'h0,         1'b1, 5};
        tbl[4] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,         4'h0,    2,      32'h00A0_0093, 1'b1, 32'h00A0_0093, 1'b0, 4};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_020C, 32'h0,         4'hF,    NO_ACK, 32'h55AA_55AA, 1'b0, 32'h0,         1'b1, 5};
        tbl[6] = '{1'b1, 1'b1, 32'h0000_0210, 32'h0BAD_F00D, 4'b1100, 0,      32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 2};

        // ---- Reset with both requests high --------------------------------
        idle_inputs();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0400;
        dm_req = 1'b1; dm_addr = 32'h0000_0800; dm_we = 1'b0; dm_be = 4'hF;
        tick();
        tick();
        check("rst_ctrl", {mem_req, mem_we, if_ready, dm_ready, err}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata_be", {mem_wdata, mem_be}, 0);
        check("rst_rdata", {if_rdata, dm_rdata}, 0);
        exp_if_rdata = '0;
        exp_dm_rdata = '0;

        // ---- Contention: both held, memory acks at once --------------------
        rst = 1'b0;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (if_ready || dm_ready) begin
                ports[ng] = {if_ready, dm_ready};
                rds[ng]   = dm_ready ? dm_rdata : if_rdata;
                ng++;
                if (ng == 4) begin
                    if_req = 1'b0; dm_req = 1'b0;
                end
            end
            mem_ack   = mem_req;
            mem_rdata = mem_addr ^ MASK;
        end
        check("contention_count", ng, 4);
        for (int k = 0; k < ng; k++) begin
            check($sformatf("contention_port%0d", k), ports[k], (k % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("contention_rdata%0d", k), rds[k],
                  (k % 2 == 0) ? (32'h0000_0800 ^ MASK) : (32'h0000_0400 ^ MASK));
        end
        exp_dm_rdata = 32'h0000_0800 ^ MASK;
        exp_if_rdata = 32'h0000_0400 ^ MASK;
        tick();
        check("contention_drained", mem_req, 0);
        idle_inputs();

        // ---- Ack while idle must be ignored --------------------------------
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (if_ready || dm_ready || mem_req) seen++;
        end
        check("stray_ack_no_activity", seen, 0);
        check("stray_ack_rdata_held", {if_rdata, dm_rdata}, {exp_if_rdata, exp_dm_rdata});
        idle_inputs();
        tick();

        // ---- Table-driven single transactions ------------------------------
        for (int i = 0; i < 7; i++) run_txn(tbl[i], i);

        // ---- Reset in the middle of REQ ------------------------------------
        if_req = 1'b1; if_addr = 32'h0000_0500;
        tick();
        tick();
        check("midreq_pending", mem_req, 1);
        rst = 1'b1;
        tick();
        check("midreq_mem_req_dropped", mem_req, 0);
        rst = 1'b0; if_req = 1'b0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (if_ready || dm_ready || err) seen++;
        end
        check("midreq_no_ready", seen, 0);
        check("midreq_rdata_cleared", {if_rdata, dm_rdata}, 0);

        fresh = '{1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'h0, 0, 32'h0000_0013, 1'b0, 32'h0000_0013, 1'b0, 2};
        run_txn(fresh, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
